// File: rtl/ahb_node_pipe_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type for the pipelined node.
package ahb_node_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // NONSEQ and SEQ are the only transfer types that need a real response.
    function automatic logic trans_active(logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_node_pipe_if.sv
// Bus bundle of the node: master side, broadcast/slave side, region config and error status.
interface ahb_node_pipe_if #(
    parameter int unsigned NB_SLAVES      = 8,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned ERR_CNT_WIDTH  = 8
);
    logic [AHB_ADDR_WIDTH-1:0] haddr_i;
    logic [AHB_DATA_WIDTH-1:0] hwdata_i;
    logic                      hsel_i;
    logic                      hwrite_i;
    logic                      hmastlock_i;
    logic [1:0]                htrans_i;
    logic [2:0]                hsize_i;
    logic [2:0]                hburst_i;
    logic [3:0]                hprot_i;
    logic                      hready_i;
    logic                      hreadyout_o;
    logic                      hresp_o;
    logic [AHB_DATA_WIDTH-1:0] hrdata_o;

    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic                      hwrite_o;
    logic                      hmastlock_o;
    logic [1:0]                htrans_o;
    logic [2:0]                hsize_o;
    logic [2:0]                hburst_o;
    logic [3:0]                hprot_o;
    logic [NB_SLAVES-1:0]      hsel_o;
    logic                      hready_o;
    logic [NB_SLAVES-1:0]      hreadyout_i;
    logic [NB_SLAVES-1:0]      hresp_i;
    logic [NB_SLAVES-1:0][AHB_DATA_WIDTH-1:0] hrdata_i;

    logic [NB_SLAVES-1:0][AHB_ADDR_WIDTH-1:0] start_addr_i;
    logic [NB_SLAVES-1:0][AHB_ADDR_WIDTH-1:0] end_addr_i;
    logic [NB_SLAVES-1:0]      region_en_i;

    logic [ERR_CNT_WIDTH-1:0]  err_cnt_o;
    logic [AHB_ADDR_WIDTH-1:0] err_addr_o;

    // Node view: it is the slave of the upstream master.
    modport slave (
        input  haddr_i, hwdata_i, hsel_i, hwrite_i, hmastlock_i, htrans_i,
               hsize_i, hburst_i, hprot_i, hready_i,
               hreadyout_i, hresp_i, hrdata_i, start_addr_i, end_addr_i, region_en_i,
        output hreadyout_o, hresp_o, hrdata_o,
               haddr_o, hwdata_o, hwrite_o, hmastlock_o, htrans_o, hsize_o, hburst_o,
               hprot_o, hsel_o, hready_o, err_cnt_o, err_addr_o
    );

    // Environment view: upstream master, peripheral slaves and configuration.
    modport master (
        output haddr_i, hwdata_i, hsel_i, hwrite_i, hmastlock_i, htrans_i,
               hsize_i, hburst_i, hprot_i, hready_i,
               hreadyout_i, hresp_i, hrdata_i, start_addr_i, end_addr_i, region_en_i,
        input  hreadyout_o, hresp_o, hrdata_o,
               haddr_o, hwdata_o, hwrite_o, hmastlock_o, htrans_o, hsize_o, hburst_o,
               hprot_o, hsel_o, hready_o, err_cnt_o, err_addr_o
    );

endinterface

// File: rtl/ahb_node_pipe_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers, error counter and address capture.
module ahb_default_slave
    import ahb_node_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              err_start,
    input  logic [ADDR_W-1:0] haddr,
    output logic              hreadyout,
    output logic              hresp,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    ds_state_e state_q, state_d;

    always_ff @(posedge clk) begin : state_reg
        if (rst) state_q <= DS_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin : next_state
        state_d   = state_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        unique case (state_q)
            DS_IDLE: if (err_start) state_d = DS_ERR1;
            DS_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = err_start ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    // Capture on every ERR1 entry; counter sticks at all-ones.
    always_ff @(posedge clk) begin : err_capture
        if (rst) begin
            err_cnt  <= '0;
            err_addr <= '0;
        end else if (state_d == DS_ERR1) begin
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            err_addr <= haddr;
        end
    end

endmodule

// File: rtl/ahb_node_pipe.sv
// AHB-Lite 1:N node with priority region decode, registered data-phase mux and default slave.
module ahb_node_pipe
    import ahb_node_pkg::*;
#(
    parameter int unsigned NB_SLAVES      = 8,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input logic            hclk_i,
    input logic            hreset_i,
    ahb_node_pipe_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(NB_SLAVES + 1);
    localparam logic [SEL_W-1:0] SEL_DEFAULT = SEL_W'(NB_SLAVES);

    logic [SEL_W-1:0] dsel_d, dsel_q;
    logic             found;
    logic             ds_start;
    logic             ds_hreadyout;
    logic             ds_hresp;

    // Lowest enabled region containing haddr wins; otherwise the default slave.
    always_comb begin : decode
        dsel_d = SEL_DEFAULT;
        found  = 1'b0;
        for (int unsigned k = 0; k < NB_SLAVES; k++) begin
            if (!found && bus.region_en_i[k] &&
                (bus.start_addr_i[k] <= bus.haddr_i) && (bus.haddr_i <= bus.end_addr_i[k])) begin
                dsel_d = SEL_W'(k);
                found  = 1'b1;
            end
        end
        if (!bus.hsel_i) dsel_d = SEL_DEFAULT;
    end

    always_comb begin : sel_onehot
        for (int unsigned k = 0; k < NB_SLAVES; k++) bus.hsel_o[k] = (dsel_d == SEL_W'(k));
    end

    assign bus.haddr_o     = bus.haddr_i;
    assign bus.hwdata_o    = bus.hwdata_i;
    assign bus.hwrite_o    = bus.hwrite_i;
    assign bus.hmastlock_o = bus.hmastlock_i;
    assign bus.htrans_o    = bus.htrans_i;
    assign bus.hsize_o     = bus.hsize_i;
    assign bus.hburst_o    = bus.hburst_i;
    assign bus.hprot_o     = bus.hprot_i;

    // Data-phase owner follows every accepted address phase, IDLE/BUSY included.
    always_ff @(posedge hclk_i) begin : dsel_reg
        if (hreset_i)          dsel_q <= SEL_DEFAULT;
        else if (bus.hready_i) dsel_q <= dsel_d;
    end

    assign ds_start = bus.hready_i && (dsel_d == SEL_DEFAULT) && trans_active(bus.htrans_i);

    ahb_default_slave #(
        .ADDR_W (AHB_ADDR_WIDTH),
        .CNT_W  (ERR_CNT_WIDTH)
    ) u_default_slave (
        .clk       (hclk_i),
        .rst       (hreset_i),
        .err_start (ds_start),
        .haddr     (bus.haddr_i),
        .hreadyout (ds_hreadyout),
        .hresp     (ds_hresp),
        .err_cnt   (bus.err_cnt_o),
        .err_addr  (bus.err_addr_o)
    );

    always_comb begin : resp_mux
        bus.hreadyout_o = ds_hreadyout;
        bus.hresp_o     = ds_hresp;
        bus.hrdata_o    = '0;
        for (int unsigned k = 0; k < NB_SLAVES; k++) begin
            if (dsel_q == SEL_W'(k)) begin
                bus.hreadyout_o = bus.hreadyout_i[k];
                bus.hresp_o     = bus.hresp_i[k];
                bus.hrdata_o    = bus.hrdata_i[k];
            end
        end
    end

    assign bus.hready_o = bus.hreadyout_o;

endmodule

// File: tb/tb_ahb_node_pipe.sv
// Scoreboard bench for ahb_node_pipe: random and directed traffic against a decode/response model.
module tb_ahb_node_pipe;
    import ahb_node_pkg::*;

    localparam int unsigned NB = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 8;

    typedef struct {
        int          kind;   // >=0 slave index, -1 default OKAY, -2 default ERROR
        logic [31:0] data;
        logic        resp;
        int unsigned cnt;
        logic [31:0] eaddr;
    } exp_t;

    logic hclk_i = 1'b0;
    logic hreset_i;

    ahb_node_pipe_if #(.NB_SLAVES(NB), .AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW), .ERR_CNT_WIDTH(CW)) bus ();

    ahb_node_pipe #(.NB_SLAVES(NB), .AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW), .ERR_CNT_WIDTH(CW)) dut (
        .hclk_i   (hclk_i),
        .hreset_i (hreset_i),
        .bus      (bus)
    );

    always #5 hclk_i = ~hclk_i;
    assign bus.hready_i = bus.hreadyout_o;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sbq[$];
    logic        mon_en = 1'b0;
    logic        wait_en = 1'b0;
    int          force_wait = 0;
    int unsigned model_cnt = 0;
    logic [31:0] model_eaddr = '0;
    logic        err_seen = 1'b0;

    logic [AW-1:0] rstart[NB];
    logic [AW-1:0] rend[NB];
    logic          ren[NB];
    logic [AW-1:0] cur_addr;
    logic [1:0]    cur_trans;
    logic          cur_sel;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [AW-1:0] a);
        for (int k = 0; k < NB; k++)
            if (ren[k] && a >= rstart[k] && a <= rend[k]) return k;
        return -1;
    endfunction

    function automatic logic [31:0] slave_data(input int k);
        return 32'hCAFE_0000 + 32'(k);
    endfunction

    function automatic logic slave_resp(input int k);
        return (k == 6);
    endfunction

    task automatic apply_cfg();
        for (int k = 0; k < NB; k++) begin
            bus.start_addr_i[k] = rstart[k];
            bus.end_addr_i[k]   = rend[k];
            bus.region_en_i[k]  = ren[k];
        end
    endtask

    task automatic cfg_clear();
        for (int k = 0; k < NB; k++) begin
            rstart[k] = '0; rend[k] = '0; ren[k] = 1'b0;
        end
    endtask

    // Peripheral slaves: fixed data/resp per port, random or forced wait states.
    always begin
        @(posedge hclk_i);
        #1;
        for (int k = 0; k < NB; k++)
            bus.hreadyout_i[k] = (force_wait > 0) ? 1'b0 :
                                 (wait_en ? ($urandom_range(0, 3) != 0) : 1'b1);
        if (force_wait > 0) force_wait--;
    end

    // Expected response for each accepted address phase goes into the scoreboard.
    always begin
        exp_t e;
        int   w;
        @(negedge hclk_i);
        if (mon_en && bus.hreadyout_o) begin
            w = cur_sel ? model_winner(cur_addr) : -1;
            if (w >= 0) begin
                e.kind = w; e.data = slave_data(w); e.resp = slave_resp(w);
            end else if (trans_active(cur_trans)) begin
                e.kind = -2; e.data = '0; e.resp = 1'b1;
                if (model_cnt < 255) model_cnt++;
                model_eaddr = cur_addr;
            end else begin
                e.kind = -1; e.data = '0; e.resp = 1'b0;
            end
            e.cnt   = model_cnt;
            e.eaddr = model_eaddr;
            @(posedge hclk_i);
            #1;
            sbq.push_back(e);
        end
    end

    // Response monitor: checks the data phase currently owned by the queue head.
    always @(negedge hclk_i) begin
        exp_t e;
        if (mon_en && sbq.size() > 0) begin
            e = sbq[0];
            if (e.kind >= 0) begin
                check("slave_ready", 64'(bus.hreadyout_o), 64'(bus.hreadyout_i[e.kind]));
                check("slave_resp", 64'(bus.hresp_o), 64'(e.resp));
                if (bus.hreadyout_o) begin
                    check("slave_rdata", 64'(bus.hrdata_o), 64'(e.data));
                    check("err_cnt_hold", 64'(bus.err_cnt_o), 64'(e.cnt));
                    void'(sbq.pop_front());
                end
            end else if (e.kind == -1) begin
                check("dflt_ok_ready", 64'(bus.hreadyout_o), 64'd1);
                check("dflt_ok_resp", 64'(bus.hresp_o), 64'd0);
                check("dflt_ok_rdata", 64'(bus.hrdata_o), 64'd0);
                void'(sbq.pop_front());
            end else if (!err_seen) begin
                check("err1_ready", 64'(bus.hreadyout_o), 64'd0);
                check("err1_resp", 64'(bus.hresp_o), 64'd1);
                if (bus.hreadyout_o) void'(sbq.pop_front());
                else err_seen = 1'b1;
            end else begin
                check("err2_ready", 64'(bus.hreadyout_o), 64'd1);
                check("err2_resp", 64'(bus.hresp_o), 64'd1);
                check("err2_rdata", 64'(bus.hrdata_o), 64'd0);
                check("err_cnt", 64'(bus.err_cnt_o), 64'(e.cnt));
                check("err_addr", 64'(bus.err_addr_o), 64'(e.eaddr));
                err_seen = 1'b0;
                void'(sbq.pop_front());
            end
        end
    end

    // Drive one address phase at posedge+1; returns at posedge+1 after it is accepted.
    task automatic issue(input logic [AW-1:0] addr, input logic [1:0] trans, input logic sel,
                         input int nwait);
        int               w;
        logic [NB-1:0]    exp_sel;
        logic [DW-1:0]    wd;
        logic             acc;
        cur_addr = addr; cur_trans = trans; cur_sel = sel;
        wd = $urandom;
        bus.haddr_i  = addr;   bus.htrans_i = trans;  bus.hsel_i = sel;
        bus.hwrite_i = 1'($urandom_range(0, 1));
        bus.hwdata_i = wd;
        bus.hprot_i  = 4'($urandom_range(0, 15));
        @(negedge hclk_i);
        w = sel ? model_winner(addr) : -1;
        exp_sel = '0;
        if (w >= 0) exp_sel[w] = 1'b1;
        check("hsel_o", 64'(bus.hsel_o), 64'(exp_sel));
        check("haddr_o", 64'(bus.haddr_o), 64'(addr));
        check("hwdata_o", 64'(bus.hwdata_o), 64'(wd));
        acc = 1'b0;
        for (int c = 0; c < 64 && !acc; c++) begin
            if (c > 0) @(negedge hclk_i);
            if (bus.hreadyout_o) begin
                acc = 1'b1;
                force_wait = nwait;
            end else begin
                bus.haddr_i = $urandom;
                @(posedge hclk_i);
                #1;
                bus.haddr_i = cur_addr;
            end
        end
        if (!acc) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: address %0h never accepted", addr);
        end
        @(posedge hclk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cfg_clear();
        apply_cfg();
        bus.hrdata_i = '0; bus.hresp_i = '0; bus.hreadyout_i = '1;
        for (int k = 0; k < NB; k++) begin
            bus.hrdata_i[k] = slave_data(k);
            bus.hresp_i[k]  = slave_resp(k);
        end
        bus.haddr_i = '0; bus.hwdata_i = '0; bus.hsel_i = 1'b1; bus.hwrite_i = 1'b0;
        bus.hmastlock_i = 1'b0; bus.htrans_i = HTRANS_IDLE; bus.hsize_i = HSIZE_WORD;
        bus.hburst_i = HBURST_SINGLE; bus.hprot_i = 4'h3;
        cur_addr = '0; cur_trans = HTRANS_IDLE; cur_sel = 1'b1;
        hreset_i = 1'b1;
        repeat (3) @(posedge hclk_i);
        @(negedge hclk_i);
        check("rst_hreadyout", 64'(bus.hreadyout_o), 64'd1);
        check("rst_hresp", 64'(bus.hresp_o), 64'd0);
        check("rst_hrdata", 64'(bus.hrdata_o), 64'd0);
        check("rst_err_cnt", 64'(bus.err_cnt_o), 64'd0);
        check("rst_err_addr", 64'(bus.err_addr_o), 64'd0);
        @(posedge hclk_i);
        #1;
        hreset_i = 1'b0;
        mon_en   = 1'b1;

        // Two adjacent regions, mapped read then unmapped write.
        rstart[0] = 32'h0000; rend[0] = 32'h0FFF; ren[0] = 1'b1;
        rstart[1] = 32'h1000; rend[1] = 32'h1FFF; ren[1] = 1'b1;
        apply_cfg();
        issue(32'h1004, HTRANS_NONSEQ, 1'b1, 0);
        issue(32'h8000, HTRANS_NONSEQ, 1'b1, 0);
        issue(32'h0000, HTRANS_IDLE, 1'b1, 0);

        // Overlap priority, then drop the winner.
        rstart[2] = 32'h3000; rend[2] = 32'h30FF; ren[2] = 1'b1;
        rstart[5] = 32'h2000; rend[5] = 32'h3FFF; ren[5] = 1'b1;
        rstart[3] = 32'h5000; rend[3] = 32'h4000; ren[3] = 1'b1;
        apply_cfg();
        issue(32'h3000, HTRANS_NONSEQ, 1'b1, 0);
        ren[2] = 1'b0;
        apply_cfg();
        issue(32'h3000, HTRANS_NONSEQ, 1'b1, 0);
        issue(32'h4800, HTRANS_SEQ, 1'b1, 0);
        issue(32'h4800, HTRANS_BUSY, 1'b1, 0);

        // Slave 0 stalls three cycles; the next address is scrambled during the stall.
        issue(32'h0010, HTRANS_NONSEQ, 1'b1, 3);
        issue(32'h1008, HTRANS_NONSEQ, 1'b1, 0);
        issue(32'h0000, HTRANS_IDLE, 1'b1, 0);

        // Random regions, addresses and wait states.
        wait_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [1:0] t;
            if (i % 40 == 0) begin
                for (int k = 0; k < NB; k++) begin
                    rstart[k] = 32'($urandom_range(0, 32'h9FFF));
                    rend[k]   = ($urandom_range(0, 7) == 0 && rstart[k] > 0) ?
                                rstart[k] - 32'd1 : rstart[k] + 32'($urandom_range(0, 32'h2FFF));
                    ren[k]    = ($urandom_range(0, 3) != 0);
                end
                apply_cfg();
            end
            t = 2'($urandom_range(0, 3));
            issue(($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'hBFFF)),
                  t, trans_active(t) ? 1'b1 : ($urandom_range(0, 7) != 0), 0);
        end
        wait_en = 1'b0;

        // Back-to-back unmapped transfers drive the counter into saturation.
        cfg_clear();
        apply_cfg();
        for (int i = 0; i < 260; i++)
            issue(32'h9000 + 32'(i * 4), (i % 2 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 0);
        issue(32'h0000, HTRANS_IDLE, 1'b1, 0);
        issue(32'h0000, HTRANS_IDLE, 1'b1, 0);
        check("err_cnt_saturated", 64'(bus.err_cnt_o), 64'd255);

        // Reset in the middle of ERR1.
        issue(32'hDEAD_0000, HTRANS_NONSEQ, 1'b1, 0);
        mon_en = 1'b0;
        bus.htrans_i = HTRANS_IDLE; cur_trans = HTRANS_IDLE;
        @(negedge hclk_i);
        check("mid_err1_ready", 64'(bus.hreadyout_o), 64'd0);
        check("mid_err1_resp", 64'(bus.hresp_o), 64'd1);
        hreset_i = 1'b1;
        @(negedge hclk_i);
        check("post_rst_ready", 64'(bus.hreadyout_o), 64'd1);
        check("post_rst_resp", 64'(bus.hresp_o), 64'd0);
        check("post_rst_err_cnt", 64'(bus.err_cnt_o), 64'd0);
        check("post_rst_err_addr", 64'(bus.err_addr_o), 64'd0);
        @(posedge hclk_i);
        #1;
        hreset_i = 1'b0;
        sbq.delete();
        err_seen = 1'b0;
        model_cnt = 0;
        model_eaddr = '0;
        mon_en = 1'b1;
        issue(32'hBEEF_0000, HTRANS_NONSEQ, 1'b1, 0);
        issue(32'h0000, HTRANS_IDLE, 1'b1, 0);
        repeat (4) @(negedge hclk_i);
        check("final_err_cnt", 64'(bus.err_cnt_o), 64'd1);
        check("final_err_addr", 64'(bus.err_addr_o), 64'hBEEF_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_node_pipe.md
Name: ahb_node_pipe

Overview:
Single-master to NB_SLAVES AHB-Lite node with address decode, a registered data-phase response multiplexer, and a built-in default slave. It is the clocked successor of the combinational node. Unmapped accesses get a protocol-correct two-cycle ERROR response instead of hanging the bus. It also adds per-region enables, deterministic overlap priority, and error capture registers. It sits between one AHB master and the peripheral slaves.

Parameters:
NB_SLAVES, 8, number of slave ports (1..16)
AHB_DATA_WIDTH, 32, HWDATA/HRDATA width
AHB_ADDR_WIDTH, 32, HADDR width
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
hclk_i  in  1  bus clock
hreset_i  in  1  synchronous active-high reset
haddr_i  in  AHB_ADDR_WIDTH  master address
hwdata_i  in  AHB_DATA_WIDTH  master write data
hsel_i  in  1  node select from master side
hwrite_i, hmastlock_i  in  1 each  master control
htrans_i  in  2  master transfer type
hsize_i / hburst_i  in  3 / 3  master size/burst
hprot_i  in  4  master protection
hready_i  in  1  bus HREADY (from hreadyout_o fabric loop)
hreadyout_o  out  1  muxed ready to master
hresp_o  out  1  muxed response to master (1 = ERROR)
hrdata_o  out  AHB_DATA_WIDTH  muxed read data
haddr_o, hwdata_o, hwrite_o, hmastlock_o, htrans_o, hsize_o, hburst_o, hprot_o  out  same widths  broadcast to all slaves
hsel_o  out  NB_SLAVES  one-hot slave select
hready_o  out  1  bus HREADY to all slaves (= hreadyout_o)
hreadyout_i  in  NB_SLAVES  per-slave ready
hresp_i  in  NB_SLAVES  per-slave response
hrdata_i  in  NB_SLAVES x AHB_DATA_WIDTH  per-slave read data
start_addr_i / end_addr_i  in  NB_SLAVES x AHB_ADDR_WIDTH  inclusive region bounds
region_en_i  in  NB_SLAVES  region enable
err_cnt_o  out  ERR_CNT_WIDTH  saturating count of ERROR responses issued by default slave
err_addr_o  out  AHB_ADDR_WIDTH  address of most recent unmapped access

Behaviour:
- Clocking and reset: single clock hclk_i. Synchronous active-high reset hreset_i. All state updates on the rising edge.
- Decode (combinational): slave k matches iff region_en_i[k] and start_addr_i[k] <= haddr_i <= end_addr_i[k], unsigned compare. The lowest matching index wins. No match, or hsel_i=0, selects the default slave. Region with start > end never matches.
- hsel_o[k] = hsel_i & winner==k. Control, address and write-data signals pass straight through, no added latency.
- Address phase is accepted when hready_i=1. The data-phase owner register dsel_q (slave index or DEFAULT) loads on every accepted cycle, including IDLE/BUSY.
- Response mux (from dsel_q): slave k gives hreadyout_i[k], hresp_i[k], hrdata_i[k]. DEFAULT gives default-slave outputs with hrdata_o=0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: hreadyout=1, hresp=0. An accepted NONSEQ/SEQ to DEFAULT goes to ERR1.
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. Goes to ERR1 if another unmapped NONSEQ/SEQ is accepted this cycle, else IDLE.
  - IDLE/BUSY to DEFAULT gives a zero-wait OKAY.
- err_cnt_o increments on each ERR1 entry and saturates at all-ones. err_addr_o loads haddr_i at that same acceptance.
- Slave wait states: while the selected hreadyout_i=0, dsel_q holds and new address-phase signals are not accepted.
- Reset values: dsel_q=DEFAULT, FSM=IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, err_cnt_o=0, err_addr_o=0.
- Reset mid-transfer abandons any ERR1/ERR2 sequence and the in-flight data phase.
- Region config change mid-transfer affects only subsequent address phases.

Decomposition:
- ahb_node_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HBURST/HSIZE encodings, and the default-slave state enum.
- Sub-module ahb_default_slave: the FSM, error counter and error address capture.
- Decoder and response mux stay in the top.

Test Plan:
- Regions 0:[0x0000,0x0FFF], 1:[0x1000,0x1FFF], NONSEQ read 0x1004 -> hsel_o=0b10; next cycle hrdata_o=hrdata_i[1]=0xCAFE0001, OKAY.
- NONSEQ write to 0x8000 (unmapped) -> then hreadyout_o=0,hresp_o=1 then 1,1; err_cnt_o=1, err_addr_o=0x8000.
- Overlap regions 2 and 5 both covering 0x3000 -> hsel_o[2]=1 only; clear region_en_i[2] -> hsel_o[5]=1.
- Slave 0 inserts 3 wait states -> hreadyout_o low 3 cycles; haddr_o changes not latched; dsel_q stays 0.
- 260 back-to-back unmapped NONSEQ with ERR_CNT_WIDTH=8 -> err_cnt_o saturates at 255; ERR2 to ERR1 chaining with no IDLE gap.
- hreset_i asserted during ERR1 -> next cycle hreadyout_o=1, hresp_o=0, err_cnt_o=0.
